// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package arith_pkg;
  localparam int ARITH_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle for serial_sub; master is the requester/consumer side.
interface serial_sub_if
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );
endinterface

// File: rtl/serial_sub_fa.sv
// One-bit full-adder slice, the shared bit-cell of the serial arithmetic blocks.
module fa (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);
  logic w_p;

  assign w_p  = a ^ b;
  assign sum  = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-adder slice.
module serial_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);
  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_nb_sh;
  logic [WIDTH-2:0]   r_diff_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic               r_zero;
  logic               r_ovf;
  logic               r_out_valid;

  logic               w_s;
  logic               w_c;
  logic [WIDTH-1:0]   w_diff_fin;
  logic               w_last;

  // Subtraction as a + ~b + ~bin: the borrow is carried as its inverted carry.
  fa u_fa (
    .sum  (w_s),
    .cout (w_c),
    .a    (r_a_sh[0]),
    .b    (r_nb_sh[0]),
    .cin  (r_carry)
  );

  assign w_diff_fin = {w_s, r_diff_sh};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_nb_sh     <= '0;
      r_diff_sh   <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a_sh  <= bus.a;
            r_nb_sh <= ~bus.b;
            r_carry <= ~bus.bin;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a_sh    <= r_a_sh >> 1;
          r_nb_sh   <= r_nb_sh >> 1;
          r_diff_sh <= w_diff_fin[WIDTH-1:1];
          r_carry   <= w_c;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // r_carry is the carry into the MSB here, w_c the carry out.
            r_diff      <= w_diff_fin;
            r_bout      <= ~w_c;
            r_ovf       <= r_carry ^ w_c;
            r_zero      <= (w_diff_fin == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.zero      = r_zero;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub at WIDTH=8 and WIDTH=4 against an integer-arithmetic reference.
module tb_serial_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8)) if8 ();
  serial_sub_if #(.WIDTH(4)) if4 ();

  serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_sub #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  logic        sel4 = 1'b0;
  logic        tv   = 1'b0;
  logic        tor  = 1'b0;
  logic        tbin = 1'b0;
  logic [31:0] ta   = '0;
  logic [31:0] tbv  = '0;

  assign if8.in_valid  = tv & !sel4;
  assign if8.out_ready = tor & !sel4;
  assign if8.a         = ta[7:0];
  assign if8.b         = tbv[7:0];
  assign if8.bin       = tbin;
  assign if4.in_valid  = tv & sel4;
  assign if4.out_ready = tor & sel4;
  assign if4.a         = ta[3:0];
  assign if4.b         = tbv[3:0];
  assign if4.bin       = tbin;

  logic        o_rdy, o_vld, o_bout, o_zero, o_ovf;
  logic [31:0] o_diff;
  always_comb begin
    o_rdy = if8.in_ready; o_vld = if8.out_valid; o_diff = {24'd0, if8.diff};
    o_bout = if8.bout; o_zero = if8.zero; o_ovf = if8.ovf;
    if (sel4) begin
      o_rdy = if4.in_ready; o_vld = if4.out_valid; o_diff = {28'd0, if4.diff};
      o_bout = if4.bout; o_zero = if4.zero; o_ovf = if4.ovf;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer subtraction.
  task automatic model(input int w, input int av, input int bv, input int binv,
                       output int d, output int bo, output int z, output int ov);
    int full, sa, sb, s;
    full = av - bv - binv;
    d    = full & ((1 << w) - 1);
    bo   = (av < bv + binv) ? 1 : 0;
    z    = (d == 0) ? 1 : 0;
    sa   = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb   = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    s    = sa - sb - binv;
    ov   = (s < -(1 << (w - 1)) || s > (1 << (w - 1)) - 1) ? 1 : 0;
  endtask

  task automatic op(input bit w4, input int av, input int bv, input int binv, input int hold);
    int w, n, ed, eb, ez, eo;
    w = w4 ? 4 : 8;
    sel4 = w4;
    model(w, av, bv, binv, ed, eb, ez, eo);
    n = 0;
    while (!o_rdy && n < 50) begin @(negedge clk); n++; end
    check("in_ready_wait", {31'd0, o_rdy}, 32'd1);
    ta = av; tbv = bv; tbin = binv[0]; tv = 1'b1;
    @(negedge clk);
    tv = 1'b0; ta = $urandom; tbv = $urandom; tbin = 1'($urandom);
    check("busy_in_ready", {31'd0, o_rdy}, 32'd0);
    n = 0;
    while (!o_vld && n < 100) begin
      @(negedge clk); n++;
      if (n == 1) begin tv = 1'b1; end
    end
    tv = 1'b0;
    check("latency", n, w);
    check("diff", o_diff, ed);
    check("flags", {29'd0, o_bout, o_zero, o_ovf}, {29'd0, eb[0], ez[0], eo[0]});
    for (int i = 0; i < hold; i++) begin
      tv = 1'($urandom); ta = $urandom; tbv = $urandom; tbin = 1'($urandom);
      @(negedge clk);
      check("bp_diff", o_diff, ed);
      check("bp_flags", {29'd0, o_bout, o_zero, o_ovf}, {29'd0, eb[0], ez[0], eo[0]});
      check("bp_ctrl", {30'd0, o_vld, o_rdy}, 32'd2);
    end
    tv = 1'b0; tor = 1'b1;
    @(negedge clk);
    tor = 1'b0;
    check("release_ctrl", {30'd0, o_vld, o_rdy}, 32'd1);
    check("idle_diff_kept", o_diff, ed);
  endtask

  initial begin
    int n, av, bv;
    #2;
    check("rst_in_ready8", {31'd0, if8.in_ready}, 32'd0);
    check("rst_in_ready4", {31'd0, if4.in_ready}, 32'd0);
    check("rst_outs8", {if8.out_valid, if8.bout, if8.zero, if8.ovf, if8.diff}, '0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, if8.in_ready}, 32'd1);

    op(0, 100, 37, 0, 0);
    op(0, 5, 9, 0, 0);
    op(0, 8'h80, 8'h01, 0, 0);
    op(0, 8'h7F, 8'hFF, 0, 0);
    op(0, 42, 41, 1, 0);
    op(0, 0, 0, 1, 0);
    op(0, 77, 200, 1, 5);

    // Abort an operation after three shift edges.
    sel4 = 1'b0;
    ta = 32'd123; tbv = 32'd45; tbin = 1'b0; tv = 1'b1;
    @(negedge clk);
    tv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, if8.in_ready}, 32'd0);
    check("midrst_outs", {if8.out_valid, if8.bout, if8.zero, if8.ovf, if8.diff}, '0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if8.out_valid) n++;
    end
    check("midrst_no_pulse", n, 0);
    op(0, 200, 100, 0, 0);

    op(1, 9, 3, 0, 0);
    op(1, 8, 1, 0, 2);

    for (int i = 0; i < 20; i++) begin
      av = int'($urandom_range(0, 255));
      bv = int'($urandom_range(0, 255));
      op(0, av, bv, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 10; i++) begin
      av = int'($urandom_range(0, 15));
      bv = int'($urandom_range(0, 15));
      op(1, av, bv, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
